// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

   typedef logic [63:0] word_t;
   typedef logic [7:0]  strobe_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } arb_state_t;

   localparam int unsigned DEF_MAX_DSTREAK = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data ports and unified memory bus, bundled for the arbiter.
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   logic          i_valid;
   logic [31:0]   i_addr;
   logic          i_ready;
   logic [31:0]   i_rdata;

   logic          d_valid;
   logic [31:0]   d_addr;
   logic          d_write;
   word_t         d_wdata;
   strobe_t       d_strobe;
   logic          d_ready;
   word_t         d_rdata;

   logic          m_valid;
   logic [31:0]   m_addr;
   logic          m_write;
   word_t         m_wdata;
   strobe_t       m_strobe;
   logic          m_ready;
   word_t         m_rdata;

   // master: the arbiter itself
   modport master (
      input  i_valid, i_addr, d_valid, d_addr, d_write, d_wdata, d_strobe,
             m_ready, m_rdata,
      output i_ready, i_rdata, d_ready, d_rdata,
             m_valid, m_addr, m_write, m_wdata, m_strobe
   );

   // slave: core requesters plus memory
   modport slave (
      output i_valid, i_addr, d_valid, d_addr, d_write, d_wdata, d_strobe,
             m_ready, m_rdata,
      input  i_ready, i_rdata, d_ready, d_rdata,
             m_valid, m_addr, m_write, m_wdata, m_strobe
   );

endinterface

// File: rtl/mem_arb_streak.sv
// Saturating count of consecutive data grants made while a fetch was waiting.
module mem_arb_streak
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_DSTREAK = DEF_MAX_DSTREAK
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       d_grant,
   input  logic       i_grant,
   input  logic       i_valid,
   output logic [3:0] streak,
   output logic       force_fetch
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

   always_ff @(posedge clk) begin
      if (!reset) begin
         streak <= '0;
      end else if (i_grant) begin
         streak <= '0;
      end else if (d_grant) begin
         if (!i_valid)
            streak <= '0;
         else if (streak < STREAK_MAX)
            streak <= streak + 4'd1;
      end
   end

   assign force_fetch = (streak == STREAK_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter: data port wins, fetch forced after a data streak.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_DSTREAK = DEF_MAX_DSTREAK
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.master bus
);

   arb_state_t  state, state_nxt;
   logic        i_grant, d_grant, force_fetch;
   logic [3:0]  streak;
   logic [31:0] addr_q;
   logic        write_q;
   word_t       wdata_q;
   strobe_t     strobe_q;

   mem_arb_streak #(.MAX_DSTREAK(MAX_DSTREAK)) u_streak (
      .clk         (clk),
      .reset       (reset),
      .d_grant     (d_grant),
      .i_grant     (i_grant),
      .i_valid     (bus.i_valid),
      .streak      (streak),
      .force_fetch (force_fetch)
   );

   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      i_grant   = 1'b0;
      d_grant   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.d_valid && !(bus.i_valid && force_fetch)) begin
               d_grant   = 1'b1;
               state_nxt = D_BUSY;
            end else if (bus.i_valid) begin
               i_grant   = 1'b1;
               state_nxt = I_BUSY;
            end
         end
         I_BUSY, D_BUSY: begin
            if (bus.m_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bus fields are captured only at grant so they stay frozen for the whole access.
   always_ff @(posedge clk) begin
      if (!reset) begin
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         strobe_q <= '0;
      end else if (d_grant) begin
         addr_q   <= bus.d_addr;
         write_q  <= bus.d_write;
         wdata_q  <= bus.d_wdata;
         strobe_q <= bus.d_strobe;
      end else if (i_grant) begin
         addr_q   <= bus.i_addr;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         strobe_q <= '0;
      end
   end

   assign bus.m_valid  = (state != IDLE);
   assign bus.m_addr   = addr_q;
   assign bus.m_write  = write_q;
   assign bus.m_wdata  = wdata_q;
   assign bus.m_strobe = strobe_q;

   assign bus.i_ready  = (state == I_BUSY) && bus.m_ready;
   assign bus.d_ready  = (state == D_BUSY) && bus.m_ready;
   assign bus.i_rdata  = bus.m_rdata[31:0];
   assign bus.d_rdata  = bus.m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected bus accesses queued at request time.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   typedef struct {
      bit          is_fetch;
      logic [31:0] addr;
      logic        write;
      word_t       wdata;
      strobe_t     strobe;
      word_t       rdata;
   } exp_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;
   exp_t sb[$];

   mem_arbiter_if bus();

   mem_arbiter #(.MAX_DSTREAK(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic push_fetch(input logic [31:0] addr, input word_t rdata);
      exp_t e;
      e.is_fetch = 1'b1;
      e.addr     = addr;
      e.write    = 1'b0;
      e.wdata    = '0;
      e.strobe   = '0;
      e.rdata    = rdata;
      sb.push_back(e);
   endtask

   task automatic push_data(input logic [31:0] addr, input logic write, input word_t wdata,
                            input strobe_t strobe, input word_t rdata);
      exp_t e;
      e.is_fetch = 1'b0;
      e.addr     = addr;
      e.write    = write;
      e.wdata    = wdata;
      e.strobe   = strobe;
      e.rdata    = rdata;
      sb.push_back(e);
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset       = 1'b0;
      bus.i_valid = 1'b0;
      bus.d_valid = 1'b0;
      bus.m_ready = 1'b0;
      cycle();
      reset = 1'b1;
   endtask

   // Memory side: wait for the access, compare it with the queue head, answer after waits.
   task automatic serve(input int waits, input bit drop);
      exp_t e;
      bit   seen;
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (bus.m_valid) begin
            seen = 1'b1;
            break;
         end
         cycle();
      end
      check("m_valid_seen", 64'(seen), 64'd1);
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (!seen || sb.size() == 0) return;
      e = sb.pop_front();
      check("m_addr",   64'(bus.m_addr),   64'(e.addr));
      check("m_write",  64'(bus.m_write),  64'(e.write));
      check("m_wdata",  bus.m_wdata,       e.wdata);
      check("m_strobe", 64'(bus.m_strobe), 64'(e.strobe));
      for (int w = 0; w < waits; w++) begin
         cycle();
         check("hold_valid",  64'(bus.m_valid),  64'd1);
         check("hold_addr",   64'(bus.m_addr),   64'(e.addr));
         check("hold_wdata",  bus.m_wdata,       e.wdata);
         check("hold_strobe", 64'(bus.m_strobe), 64'(e.strobe));
         check("hold_no_rdy", 64'({bus.i_ready, bus.d_ready}), 64'd0);
      end
      bus.m_ready = 1'b1;
      bus.m_rdata = e.rdata;
      #1;
      check("i_ready", 64'(bus.i_ready), 64'(e.is_fetch));
      check("d_ready", 64'(bus.d_ready), 64'(!e.is_fetch));
      if (e.is_fetch)
         check("i_rdata", 64'(bus.i_rdata), 64'(e.rdata[31:0]));
      else
         check("d_rdata", bus.d_rdata, e.rdata);
      cycle();
      check("bubble", 64'(bus.m_valid), 64'd0);
      bus.m_ready = 1'b0;
      bus.m_rdata = '0;
      if (drop) begin
         if (e.is_fetch) bus.i_valid = 1'b0;
         else            bus.d_valid = 1'b0;
      end
   endtask

   initial begin
      n_checks     = 0;
      n_pass       = 0;
      reset        = 1'b0;
      bus.i_valid  = 1'b0;
      bus.i_addr   = '0;
      bus.d_valid  = 1'b0;
      bus.d_addr   = '0;
      bus.d_write  = 1'b0;
      bus.d_wdata  = '0;
      bus.d_strobe = '0;
      bus.m_ready  = 1'b0;
      bus.m_rdata  = '0;
      @(negedge clk);

      // Reset held with both requesters asking.
      bus.i_valid = 1'b1;
      bus.i_addr  = 32'h0000_1000;
      bus.d_valid = 1'b1;
      bus.d_addr  = 32'h0000_0040;
      for (int c = 0; c < 3; c++) begin
         cycle();
         check("rst_m_valid", 64'(bus.m_valid), 64'd0);
         check("rst_readys",  64'({bus.i_ready, bus.d_ready}), 64'd0);
      end
      check("rst_m_addr",   64'(bus.m_addr),   64'd0);
      check("rst_m_wdata",  bus.m_wdata,       64'd0);
      check("rst_m_strobe", 64'(bus.m_strobe), 64'd0);
      check("rst_m_write",  64'(bus.m_write),  64'd0);
      reset = 1'b1;
      push_data(32'h0000_0040, 1'b0, '0, '0, 64'h1111_2222_3333_4444);
      push_fetch(32'h0000_1000, 64'h5555_6666_0000_0001);
      serve(0, 1'b1);
      serve(0, 1'b1);

      // Lone fetch, zero-wait memory.
      do_reset();
      bus.i_valid = 1'b1;
      bus.i_addr  = 32'h8000_0000;
      push_fetch(32'h8000_0000, 64'hABCD_0000_0000_0013);
      check("lat_before", 64'(bus.m_valid), 64'd0);
      cycle();
      check("lat_fetch", 64'(bus.m_valid), 64'd1);
      serve(0, 1'b1);

      // Contention with a slow memory: data first, then fetch.
      do_reset();
      bus.i_valid = 1'b1;
      bus.i_addr  = 32'h8000_0004;
      bus.d_valid = 1'b1;
      bus.d_addr  = 32'h0000_0100;
      bus.d_write = 1'b0;
      push_data(32'h0000_0100, 1'b0, '0, '0, 64'h0123_4567_89AB_CDEF);
      push_fetch(32'h8000_0004, 64'hFFFF_FFFF_0000_0093);
      serve(3, 1'b1);
      serve(3, 1'b1);

      // Both held: starvation guard yields D,D,D,D,I.
      do_reset();
      bus.i_valid = 1'b1;
      bus.i_addr  = 32'h8000_0010;
      bus.d_valid = 1'b1;
      bus.d_addr  = 32'h0000_0180;
      for (int r = 0; r < 2; r++) begin
         for (int n = 0; n < 4; n++)
            push_data(32'h0000_0180, 1'b0, '0, '0, 64'(r * 16 + n));
         push_fetch(32'h8000_0010, 64'(32'h100 + r));
         for (int n = 0; n < 4; n++)
            serve(0, 1'b0);
         check("streak_max", 64'(dut.u_streak.streak), 64'd4);
         serve(1, 1'b0);
         check("streak_after_i", 64'(dut.u_streak.streak), 64'd0);
      end
      bus.i_valid = 1'b0;
      bus.d_valid = 1'b0;

      // Store with byte enables, held through wait states.
      do_reset();
      bus.d_valid  = 1'b1;
      bus.d_addr   = 32'h0000_0200;
      bus.d_write  = 1'b1;
      bus.d_wdata  = 64'hDEAD_BEEF_0000_1111;
      bus.d_strobe = 8'h0F;
      push_data(32'h0000_0200, 1'b1, 64'hDEAD_BEEF_0000_1111, 8'h0F, 64'h0);
      serve(2, 1'b1);
      bus.d_write  = 1'b0;
      bus.d_strobe = '0;
      bus.d_wdata  = '0;

      // Reset during a data access, then a stray completion in IDLE.
      bus.d_valid = 1'b1;
      bus.d_addr  = 32'h0000_0300;
      cycle();
      check("abort_busy", 64'(bus.m_valid), 64'd1);
      reset = 1'b0;
      cycle();
      check("abort_m_valid", 64'(bus.m_valid), 64'd0);
      check("abort_d_ready", 64'(bus.d_ready), 64'd0);
      check("abort_m_addr",  64'(bus.m_addr),  64'd0);
      reset       = 1'b1;
      bus.d_valid = 1'b0;
      bus.m_ready = 1'b1;
      bus.m_rdata = 64'h7777_7777_7777_7777;
      #1;
      check("stray_readys", 64'({bus.i_ready, bus.d_ready}), 64'd0);
      cycle();
      check("stray_m_valid", 64'(bus.m_valid), 64'd0);
      check("stray_readys2", 64'({bus.i_ready, bus.d_ready}), 64'd0);
      bus.m_ready = 1'b0;
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
